io_periph_bank: RTL

Memory-mapped peripheral bank that answers the MMU's I/O port (0x80000000–0x800000FF, presented as an 8-bit byte offset). It provides a GPIO output register, a synchronized GPIO input, a 32-bit compare timer with interrupt, and an 8N1 UART transmitter behind a small FIFO. It is the responder on the `io_*` interface and sits beside the MMU at the top level.

---
 rtl/io_periph_bank.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/io_periph_bank.sv
// Memory-mapped I/O bank: GPIO out/in, compare timer with level interrupt,
// and an 8N1 UART transmitter fed by a small byte FIFO.
module io_periph_bank #(
    parameter int TX_DEPTH     = 4,
    parameter int TX_DEPTH_LOG = 2,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        uart_tx,
    output logic        irq
);
    localparam logic [5:0] A_GPIO_OUT = 6'd0;
    localparam logic [5:0] A_GPIO_IN  = 6'd1;
    localparam logic [5:0] A_COUNT    = 6'd2;
    localparam logic [5:0] A_CMP      = 6'd3;
    localparam logic [5:0] A_CTRL     = 6'd4;
    localparam logic [5:0] A_UDATA    = 6'd5;
    localparam logic [5:0] A_USTAT    = 6'd6;
    localparam logic [5:0] A_UDIV     = 6'd7;
    localparam logic [TX_DEPTH_LOG:0] FULL_CNT = (TX_DEPTH_LOG+1)'(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic [5:0]  sel_s;
    logic        wr_s;
    logic [31:0] gpio_out_q, sync1_q, sync2_q;
    logic [31:0] tmr_cnt_q, tmr_cnt_d, tmr_cmp_q, tmr_cmp_d;
    logic        tmr_en_q, tmr_en_d, tmr_aclr_q, tmr_aclr_d;
    logic        tmr_irqen_q, tmr_irqen_d, tmr_match_q, tmr_match_d, irq_q;
    logic [7:0]  fifo_mem_q [TX_DEPTH];
    logic [TX_DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [TX_DEPTH_LOG:0]   fifo_cnt_q, fifo_cnt_d;
    logic        full_s, empty_s, push_s, push_ok_s, pop_s, ovf_q, ovf_d;
    logic [15:0] div_q, baud_q, period_m1_s;
    tx_state_t   state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        tx_q;

    assign sel_s     = io_addr[7:2];
    assign wr_s      = io_en & io_we;
    assign full_s    = (fifo_cnt_q == FULL_CNT);
    assign empty_s   = (fifo_cnt_q == '0);
    assign push_s    = wr_s && (sel_s == A_UDATA);
    assign push_ok_s = push_s && !full_s;
    // A byte leaves the FIFO when the transmitter starts a frame, either from idle or straight out of a stop bit.
    assign pop_s     = !empty_s && ((state_q == S_IDLE) ||
                                    ((state_q == S_STOP) && (baud_q == 16'd0)));
    assign period_m1_s = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

    assign gpio_out = gpio_out_q;
    assign uart_tx  = tx_q;
    assign irq      = irq_q;

    // Read mux: zero when idle or for unmapped / write-only offsets.
    always_comb begin
        io_data_read = 32'd0;
        if (io_en) begin
            case (sel_s)
                A_GPIO_OUT: io_data_read = gpio_out_q;
                A_GPIO_IN:  io_data_read = sync2_q;
                A_COUNT:    io_data_read = tmr_cnt_q;
                A_CMP:      io_data_read = tmr_cmp_q;
                A_CTRL:     io_data_read = {23'd0, tmr_match_q, 5'd0, tmr_irqen_q, tmr_aclr_q, tmr_en_q};
                A_USTAT:    io_data_read = {16'd0, 8'(fifo_cnt_q), 4'd0, ovf_q, (state_q != S_IDLE), empty_s, full_s};
                A_UDIV:     io_data_read = {16'd0, div_q};
                default:    io_data_read = 32'd0;
            endcase
        end else begin
            io_data_read = 32'd0;
        end
    end

    // Timer next state; a COUNT write suppresses that cycle's compare, and a new match beats W1C.
    always_comb begin
        tmr_cnt_d   = tmr_cnt_q;
        tmr_cmp_d   = tmr_cmp_q;
        tmr_en_d    = tmr_en_q;
        tmr_aclr_d  = tmr_aclr_q;
        tmr_irqen_d = tmr_irqen_q;
        tmr_match_d = tmr_match_q;
        if (wr_s && (sel_s == A_CMP)) begin
            tmr_cmp_d = io_data_write;
        end else begin
            tmr_cmp_d = tmr_cmp_q;
        end
        if (wr_s && (sel_s == A_CTRL)) begin
            tmr_en_d    = io_data_write[0];
            tmr_aclr_d  = io_data_write[1];
            tmr_irqen_d = io_data_write[2];
            if (io_data_write[8]) begin
                tmr_match_d = 1'b0;
            end else begin
                tmr_match_d = tmr_match_q;
            end
        end else begin
            tmr_en_d = tmr_en_q;
        end
        if (wr_s && (sel_s == A_COUNT)) begin
            tmr_cnt_d = io_data_write;
        end else if (tmr_en_q) begin
            if (tmr_cnt_q == tmr_cmp_q) begin
                tmr_match_d = 1'b1;
                tmr_cnt_d   = tmr_aclr_q ? 32'd0 : tmr_cnt_q + 32'd1;
            end else begin
                tmr_cnt_d = tmr_cnt_q + 32'd1;
            end
        end else begin
            tmr_cnt_d = tmr_cnt_q;
        end
    end

    // FIFO occupancy and overflow flag; a push while full is dropped even if a pop happens.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push_ok_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        ovf_d = ovf_q;
        if (push_s && full_s) begin
            ovf_d = 1'b1;
        end else if (wr_s && (sel_s == A_USTAT) && io_data_write[3]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Register file, timer, synchronizer and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out_q  <= 32'd0;
            sync1_q     <= 32'd0;
            sync2_q     <= 32'd0;
            tmr_cnt_q   <= 32'd0;
            tmr_cmp_q   <= 32'd0;
            tmr_en_q    <= 1'b0;
            tmr_aclr_q  <= 1'b0;
            tmr_irqen_q <= 1'b0;
            tmr_match_q <= 1'b0;
            irq_q       <= 1'b0;
            div_q       <= 16'(CLKS_PER_BIT);
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (wr_s && (sel_s == A_GPIO_OUT)) gpio_out_q <= io_data_write;
            if (wr_s && (sel_s == A_UDIV))     div_q      <= io_data_write[15:0];
            sync1_q     <= gpio_in;
            sync2_q     <= sync1_q;
            tmr_cnt_q   <= tmr_cnt_d;
            tmr_cmp_q   <= tmr_cmp_d;
            tmr_en_q    <= tmr_en_d;
            tmr_aclr_q  <= tmr_aclr_d;
            tmr_irqen_q <= tmr_irqen_d;
            tmr_match_q <= tmr_match_d;
            irq_q       <= tmr_match_d & tmr_irqen_d;
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_s)     rd_ptr_q <= rd_ptr_q + 1'b1;
            fifo_cnt_q  <= fifo_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; contents are meaningless while the count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) fifo_mem_q[wr_ptr_q] <= io_data_write[7:0];
    end

    // UART TX FSM; the bit period is reloaded from UART_DIV at every bit boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop_s) begin
                        state_q <= S_START;
                        shift_q <= fifo_mem_q[rd_ptr_q];
                        baud_q  <= period_m1_s;
                        tx_q    <= 1'b0;
                    end else begin
                        tx_q    <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_q != 16'd0) begin
                        baud_q <= baud_q - 16'd1;
                    end else begin
                        state_q   <= S_DATA;
                        baud_q    <= period_m1_s;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (baud_q != 16'd0) begin
                        baud_q <= baud_q - 16'd1;
                    end else if (bit_idx_q == 3'd7) begin
                        state_q <= S_STOP;
                        baud_q  <= period_m1_s;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q    <= period_m1_s;
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                S_STOP: begin
                    if (baud_q != 16'd0) begin
                        baud_q <= baud_q - 16'd1;
                    end else if (pop_s) begin
                        state_q <= S_START;
                        shift_q <= fifo_mem_q[rd_ptr_q];
                        baud_q  <= period_m1_s;
                        tx_q    <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end
endmodule
